// File: rtl/wb_gpio_in.sv
// Wishbone classic slave sampling up to 32 asynchronous input pins.
// Per-pin edge detection into sticky W1C status bits with a maskable registered interrupt.
module wb_gpio_in #(
    parameter int unsigned N_INPUTS  = 32,
    parameter logic [31:0] RESET_POL = 32'hFFFF_FFFF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    input  logic [N_INPUTS-1:0] gpio_i,
    output logic                irq_o
);

    // Unimplemented pins are forced to 0 in every register through this mask.
    localparam logic [31:0] IMPL = (N_INPUTS >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << N_INPUTS) - 32'd1);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_POL  = 2'd3;

    logic [31:0] pins;
    logic [31:0] s1_q, s2_q, prev_q;
    logic [31:0] status_q, status_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] pol_q, pol_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, irq_q;

    logic        req, wr, rd;
    logic [1:0]  adr;
    logic [31:0] lane, wbits, edge_det, clr, rdata;

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    always_comb begin
        pins                 = '0;
        pins[N_INPUTS-1:0]   = gpio_i;
    end

    assign adr   = wb_adr_i[3:2];
    assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr    = req & wb_we_i;
    assign rd    = req & ~wb_we_i;
    assign lane  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wbits = wb_dat_i & lane & IMPL;

    assign edge_det = ((pol_q & s2_q & ~prev_q) | (~pol_q & ~s2_q & prev_q)) & IMPL;
    assign clr      = (wr && adr == A_STAT) ? wbits : 32'h0;
    // A new edge in the same cycle as its clear keeps the bit set.
    assign status_d = (status_q & ~clr) | edge_det;
    assign mask_d   = (wr && adr == A_MASK) ? ((mask_q & ~lane) | wbits) : mask_q;
    assign pol_d    = (wr && adr == A_POL)  ? ((pol_q  & ~lane) | wbits) : pol_q;

    always_comb begin
        rdata = 32'h0;
        case (adr)
            A_DATA:  rdata = s2_q;
            A_STAT:  rdata = status_q;
            A_MASK:  rdata = mask_q;
            default: rdata = pol_q;
        endcase
    end

    assign dat_d = rd ? rdata : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            pol_q    <= RESET_POL & IMPL;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            s1_q     <= pins;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            status_q <= status_d;
            mask_q   <= mask_d;
            pol_q    <= pol_d;
            dat_q    <= dat_d;
            ack_q    <= req;
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign irq_o    = irq_q;

endmodule
